// File: rtl/window_pulse_pkg.sv
// window_pulse_pkg: shared state and register-map definitions
// for the programmable multi-channel window pulse generator.
package window_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int SEL_PERIOD  = 0;
  localparam int SEL_LO_BASE = 1;

  function automatic int sel_lo(input int k);
    return SEL_LO_BASE + 2 * k;
  endfunction

  function automatic int sel_hi(input int k);
    return SEL_LO_BASE + 2 * k + 1;
  endfunction

endpackage

// File: rtl/window_cmp.sv
// window_cmp: one channel -- active lo/hi, window comparator, out register.
// With WINDOW_EDGE_IRQ_EN defined, adds a window-entry irq pulse.
module window_cmp
  import window_pulse_pkg::*;
#(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  state_t           state,
  input  logic             load,
  input  logic             step,
  input  logic [CNT_W-1:0] stg_lo,
  input  logic [CNT_W-1:0] stg_hi,
  input  logic [CNT_W-1:0] count,
  output logic             out
`ifdef WINDOW_EDGE_IRQ_EN
  ,
  output logic             irq
`endif
);

  typedef struct packed {
    logic [CNT_W-1:0] lo;
    logic [CNT_W-1:0] hi;
  } ch_cfg_t;

  ch_cfg_t act;
  logic    inwin;

  assign inwin = (count > act.lo) && (count < act.hi);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act <= '0;
      out <= 1'b0;
    end else begin
      if (load) begin
        act.lo <= stg_lo;
        act.hi <= stg_hi;
      end
      // out only advances with the counter, so a pause freezes it too
      if (state == IDLE)
        out <= 1'b1;
      else if (step)
        out <= ~inwin;
    end
  end

`ifdef WINDOW_EDGE_IRQ_EN
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= 1'b0;
      irq  <= 1'b0;
    end else begin
      prev <= out;
      irq  <= prev & ~out;
    end
  end
`endif

endmodule

// File: rtl/window_pulse_gen.sv
// window_pulse_gen: periodic counter driving N_CH low-active windows.
// Optional WINDOW_EDGE_IRQ_EN adds per-channel window-entry irq pulses.
module window_pulse_gen
  import window_pulse_pkg::*;
#(
  parameter  int CNT_W      = 13,
  parameter  int N_CH       = 2,
  parameter  int DEF_PERIOD = 4600,
  localparam int SEL_W      = $clog2(2 * N_CH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             oneshot,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic [N_CH-1:0]  out,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             busy
`ifdef WINDOW_EDGE_IRQ_EN
  ,
  output logic [N_CH-1:0]  irq
`endif
);

  state_t           state;
  logic             os_mode;
  logic             step;
  logic             at_end;
  logic             load;
  logic [CNT_W-1:0] stg_period;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] stg_lo [N_CH];
  logic [CNT_W-1:0] stg_hi [N_CH];

  assign step   = (state != IDLE) && en;
  assign at_end = (count == act_period);
  assign load   = (state == IDLE) || (step && at_end);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_period <= CNT_W'(DEF_PERIOD);
      for (int k = 0; k < N_CH; k++) begin
        stg_lo[k] <= '0;
        stg_hi[k] <= '0;
      end
    end else if (cfg_we) begin
      if (int'(cfg_sel) == SEL_PERIOD)
        stg_period <= cfg_wdata;
      for (int k = 0; k < N_CH; k++) begin
        if (int'(cfg_sel) == sel_lo(k))
          stg_lo[k] <= cfg_wdata;
        if (int'(cfg_sel) == sel_hi(k))
          stg_hi[k] <= cfg_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      os_mode    <= 1'b0;
      count      <= '0;
      wrap       <= 1'b0;
      act_period <= CNT_W'(DEF_PERIOD);
    end else begin
      wrap <= step && at_end;
      if (load)
        act_period <= stg_period;
      if (step)
        count <= at_end ? '0 : count + CNT_W'(1);
      unique case (state)
        IDLE: begin
          if (en && (!oneshot || start)) begin
            state   <= RUN;
            os_mode <= oneshot;
          end
        end
        RUN, PAUSE: begin
          if (!en)
            state <= PAUSE;
          else if (at_end && os_mode)
            state <= IDLE;
          else
            state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    window_cmp #(
      .CNT_W(CNT_W)
    ) u_cmp (
      .clk   (clk),
      .reset (reset),
      .state (state),
      .load  (load),
      .step  (step),
      .stg_lo(stg_lo[k]),
      .stg_hi(stg_hi[k]),
      .count (count),
      .out   (out[k])
`ifdef WINDOW_EDGE_IRQ_EN
      ,
      .irq   (irq[k])
`endif
    );
  end

endmodule

// File: doc/window_pulse_gen.md
Name: window_pulse_gen

Overview:
- Programmable multi-channel periodic window generator.
- A free-running period counter drives N_CH outputs. Each output is high except inside a per-channel programmable window, where it is low.
- Successor to the fixed two-output, fixed-period generator. Adds parametrised width and channel count, runtime configuration with wrap-synchronised shadow registers, pause, and one-shot mode.

Parameters:
- CNT_W, 13, counter and config data width.
- N_CH, 2, number of window outputs.
- DEF_PERIOD, 4600, terminal count loaded at reset. Period = DEF_PERIOD+1 cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  run enable. Low in RUN pauses the block.
- oneshot  in  1  1 = single period per start, 0 = continuous. Sampled on leaving IDLE.
- start  in  1  one-shot trigger, level-sampled in IDLE.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  $clog2(2*N_CH+1)  register select: 0 = period; 2k+1 = lo[k]; 2k+2 = hi[k].
- cfg_wdata  in  CNT_W  write data.
- out  out  N_CH  window outputs: low inside window, high outside, 0 under reset.
- count  out  CNT_W  current counter value.
- wrap  out  1  one-cycle pulse when the counter returns to 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, active-low) values:
  - counter = 0, out = 0, wrap = 0, busy = 0, state = IDLE.
  - Staging and active period = DEF_PERIOD; all lo/hi = 0.
- Config registers:
  - cfg_we writes the staging register at the next clk edge.
  - cfg_sel > 2*N_CH is ignored.
  - Active registers load from staging on every wrap and every cycle in IDLE, never mid-period.
- States:
  - IDLE: counter held at 0, out = all 1s.
    - Continuous: go to RUN when en=1.
    - One-shot: go to RUN when en=1 and start=1.
  - RUN: counter increments each cycle.
    - At counter == active period: counter -> 0 and wrap=1 in the next cycle.
    - One-shot: RUN -> IDLE at that wrap.
    - en=0: go to PAUSE.
  - PAUSE: counter and out hold their values. en=1 returns to RUN.
- Window output, per channel k, registered from the current counter value (1-cycle latency vs count):
  - out[k] <= !(count > lo[k] && count < hi[k]), unsigned, strict comparisons.
  - lo >= hi-1 gives an empty window (output constantly high).
  - hi > period: window runs to the end of the period.
- Period edge cases:
  - Active period = 0: counter stays 0 and wrap pulses every RUN cycle.
  - Counter never exceeds the active period. A reload to a smaller period takes effect only after the wrap.
- Simultaneous events:
  - cfg_we together with a wrap: the active register takes the old staging value; the new value applies at the next wrap.
  - start outside IDLE is ignored.
- Reset mid-operation: immediate return to reset values, including staging registers.

Optional Feature:
- Macro: WINDOW_EDGE_IRQ_EN.
- When defined:
  - Adds output irq [N_CH].
  - irq[k] is a one-cycle pulse registered on each 1->0 transition of out[k] (window entry).
  - No pulse on reset release or on the IDLE -> RUN entry.
- When undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package window_pulse_pkg:
  - state enum state_t {IDLE, RUN, PAUSE}.
  - cfg_sel constants SEL_PERIOD and SEL_LO_BASE.
  - Struct ch_cfg_t {lo, hi}, parameterised by CNT_W in the module.
- Sub-module window_cmp:
  - One channel: active lo/hi registers, comparator, out register.
  - Plus irq edge detection when WINDOW_EDGE_IRQ_EN is defined.
  - Instantiated N_CH times via generate.

Test Plan:
- Defaults, continuous, en=1, cfg lo0=3850 hi0=4150 lo1=3200 hi1=3800 written in IDLE:
  - out[0] low for counts 3851..4149 (one cycle later).
  - out[1] low for counts 3201..3799.
  - wrap after count 4600; period 4601 cycles, repeating.
- Mid-period write period=9 at count 100:
  - Counter continues to 4600, wraps.
  - Thereafter wrap every 10 cycles.
- One-shot, period=20, start pulse:
  - busy high for 21 cycles, single wrap, return to IDLE with out=1s.
  - Second start during busy is ignored.
- en dropped at count 50 for 7 cycles: count and out frozen at 50, resume at 51 with no skipped window cycles.
- Async reset asserted mid-window, between clock edges: out=0, count=0, busy=0 immediately; active period back to 4600.
- With WINDOW_EDGE_IRQ_EN, lo0=5 hi0=8, period=10: irq[0] pulses once per period, one cycle after out[0] falls, never on reset release.
